pc_sequencer: RTL and testbench

- Next-PC controller for the fetch stage. Computes the address loaded into the program counter register each cycle.
- Arbitrates between sequential increment, branch redirect, jump redirect, halt/resume and pipeline stall.
- Drives the PC hold control and the IF/ID flush.
- Sits between main control, hazard unit and the PC register. next_pc feeds the PC register input; pc_hold feeds its hold input.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC sequencer for fetch; next_pc/pc_hold combinational, flush/halted/redirect_cnt registered.
// Stall holds the PC; optional exception redirect enabled by PC_SEQ_EXCEPTION_EN.
// Priority in RUN/FLUSH: [exception >] jump > branch > halt > stall > sequential.
module pc_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter int                PC_INCR      = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cur_pc,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
`ifdef PC_SEQ_EXCEPTION_EN
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_vector,
  output logic [ADDR_W-1:0] epc,
`endif
  output logic [ADDR_W-1:0] next_pc,
  output logic              pc_hold,
  output logic              flush,
  output logic              halted,
  output logic [7:0]        redirect_cnt
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [1:0]        fcnt, fcnt_nxt;
  logic              redirect;
  logic              accept;
  logic [ADDR_W-1:0] redir_pc;
  logic              active;

  assign active = (state == S_RUN) || (state == S_FLUSH);

  always_comb begin
    redirect = 1'b0;
    redir_pc = jump_target;
`ifdef PC_SEQ_EXCEPTION_EN
    if (exc_req) begin
      redirect = 1'b1;
      redir_pc = exc_vector;
    end else
`endif
    if (jump_en) begin
      redirect = 1'b1;
      redir_pc = jump_target;
    end else if (branch_taken) begin
      redirect = 1'b1;
      redir_pc = branch_target;
    end
  end

  always_comb begin
    next_pc   = cur_pc + ADDR_W'(PC_INCR);
    pc_hold   = 1'b0;
    state_nxt = state;
    fcnt_nxt  = fcnt;
    accept    = 1'b0;
    case (state)
      S_BOOT: begin
        next_pc   = RESET_VECTOR;
        state_nxt = S_RUN;
      end
      S_HALTED: begin
        next_pc = cur_pc;
        pc_hold = 1'b1;
        if (resume_req) state_nxt = S_RUN;
      end
      default: begin
        // The flush counter keeps running underneath stalls.
        if (state == S_FLUSH) begin
          if (fcnt == 2'd0) state_nxt = S_RUN;
          else              fcnt_nxt  = fcnt - 2'd1;
        end
        if (redirect) begin
          next_pc   = redir_pc;
          state_nxt = S_FLUSH;
          fcnt_nxt  = 2'(FLUSH_CYCLES - 1);
          accept    = 1'b1;
        end else if (halt_req) begin
          next_pc   = cur_pc;
          pc_hold   = 1'b1;
          state_nxt = S_HALTED;
        end else if (stall) begin
          next_pc = cur_pc;
          pc_hold = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_BOOT;
      fcnt         <= 2'd0;
      redirect_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (accept && redirect_cnt != 8'hFF) redirect_cnt <= redirect_cnt + 8'd1;
    end
  end

`ifdef PC_SEQ_EXCEPTION_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  epc <= '0;
    else if (active && exc_req) epc <= cur_pc;
  end
`endif

  assign flush  = (state == S_BOOT) || (state == S_FLUSH);
  assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; inputs change 1ns after posedge, outputs checked at negedge.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cur_pc;
  logic        stall, halt_req, resume_req, branch_taken, jump_en;
  logic [15:0] branch_target, jump_target;
  logic [15:0] next_pc;
  logic        pc_hold, flush, halted;
  logic [7:0]  redirect_cnt;
`ifdef PC_SEQ_EXCEPTION_EN
  logic        exc_req;
  logic [15:0] exc_vector, epc;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .cur_pc(cur_pc), .stall(stall), .halt_req(halt_req),
    .resume_req(resume_req), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_en(jump_en), .jump_target(jump_target),
`ifdef PC_SEQ_EXCEPTION_EN
    .exc_req(exc_req), .exc_vector(exc_vector), .epc(epc),
`endif
    .next_pc(next_pc), .pc_hold(pc_hold), .flush(flush), .halted(halted),
    .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    stall = 0; halt_req = 0; resume_req = 0; branch_taken = 0; jump_en = 0;
    branch_target = 16'h0; jump_target = 16'h0;
`ifdef PC_SEQ_EXCEPTION_EN
    exc_req = 0; exc_vector = 16'h0;
`endif
  endtask

  initial begin
    rst = 1'b0;
    cur_pc = 16'h1234;
    clr();
    #2;
    chk("rst_next_pc", next_pc, 16'h0000);
    chk("rst_flush", flush, 1);
    chk("rst_hold", pc_hold, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", redirect_cnt, 0);

    // Release reset: BOOT cycle, then sequential fetch
    tick(); rst = 1'b1;
    mid();
    chk("boot_next_pc", next_pc, 16'h0000);
    chk("boot_flush", flush, 1);
    chk("boot_hold", pc_hold, 0);
    cur_pc = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick(); mid();
      chk("seq_next_pc", next_pc, cur_pc + 16'h2);
      chk("seq_hold", pc_hold, 0);
      chk("seq_flush", flush, 0);
      cur_pc = cur_pc + 16'h2;
    end

    // Stall two cycles
    tick(); cur_pc = 16'h0010; stall = 1; mid();
    chk("stall1_pc", next_pc, 16'h0010);
    chk("stall1_hold", pc_hold, 1);
    tick(); mid();
    chk("stall2_pc", next_pc, 16'h0010);
    chk("stall2_hold", pc_hold, 1);
    tick(); stall = 0; mid();
    chk("unstall_pc", next_pc, 16'h0012);
    chk("unstall_hold", pc_hold, 0);

    // Branch overriding stall
    tick(); cur_pc = 16'h0020; branch_taken = 1; branch_target = 16'h0100; stall = 1; mid();
    chk("br_pc", next_pc, 16'h0100);
    chk("br_hold", pc_hold, 0);
    chk("br_flush_now", flush, 0);
    tick(); clr(); cur_pc = 16'h0100; mid();
    chk("br_flush_next", flush, 1);
    chk("br_cnt", redirect_cnt, 1);
    chk("br_seq_pc", next_pc, 16'h0102);
    tick(); cur_pc = 16'h0102; mid();
    chk("br_flush_end", flush, 0);

    // Jump beats branch; halt deferred
    tick(); cur_pc = 16'h0104; jump_en = 1; jump_target = 16'h0200;
    branch_taken = 1; branch_target = 16'h0300; halt_req = 1; mid();
    chk("jmp_pc", next_pc, 16'h0200);
    chk("jmp_hold", pc_hold, 0);
    tick(); jump_en = 0; branch_taken = 0; cur_pc = 16'h0200; mid();
    chk("halt_acc_hold", pc_hold, 1);
    chk("halt_acc_halted", halted, 0);
    chk("jmp_cnt", redirect_cnt, 2);
    tick(); halt_req = 0; jump_en = 1; branch_taken = 1; mid();
    chk("halted", halted, 1);
    chk("halted_hold", pc_hold, 1);
    chk("halted_pc", next_pc, 16'h0200);
    tick(); jump_en = 0; branch_taken = 0; mid();
    chk("halted_cnt", redirect_cnt, 2);
    chk("halted_still", halted, 1);
    tick(); resume_req = 1; mid();
    chk("resume_hold", pc_hold, 1);
    chk("resume_halted", halted, 1);
    tick(); resume_req = 0; mid();
    chk("run_halted", halted, 0);
    chk("run_hold", pc_hold, 0);
    chk("run_pc", next_pc, 16'h0202);

    // Wrap-around
    tick(); cur_pc = 16'hFFFE; mid();
    chk("wrap_pc", next_pc, 16'h0000);

`ifdef PC_SEQ_EXCEPTION_EN
    tick(); cur_pc = 16'h0040; exc_req = 1; exc_vector = 16'h0080;
    jump_en = 1; jump_target = 16'h0200; mid();
    chk("exc_pc", next_pc, 16'h0080);
    tick(); clr(); cur_pc = 16'h0080; mid();
    chk("exc_epc", epc, 16'h0040);
    chk("exc_flush", flush, 1);
    chk("exc_cnt", redirect_cnt, 3);
`endif

    // Redirect counter saturation
    tick(); branch_taken = 1; branch_target = 16'h0400;
    for (int i = 0; i < 300; i++) tick();
    branch_taken = 0; mid();
    chk("sat_cnt", redirect_cnt, 8'd255);

    // Reset while halted
    tick(); halt_req = 1;
    tick(); halt_req = 0; mid();
    chk("halt2", halted, 1);
    #1 rst = 1'b0; #1;
    chk("arst_halted", halted, 0);
    chk("arst_flush", flush, 1);
    chk("arst_pc", next_pc, 16'h0000);
    chk("arst_hold", pc_hold, 0);
    chk("arst_cnt", redirect_cnt, 0);
    tick(); rst = 1'b1; mid();
    chk("boot2_pc", next_pc, 16'h0000);
    chk("boot2_flush", flush, 1);
    tick(); cur_pc = 16'h0000; mid();
    chk("boot2_seq", next_pc, 16'h0002);
    chk("boot2_noflush", flush, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
